// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with mid-bit sampling, framing-error strobe and break lockout.
module uart_rx #(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic       i_Clock,
   input  logic       i_Rst,
   input  logic       i_RX_Serial,
   output logic       o_RX_DV,
   output logic [7:0] o_RX_Byte,
   output logic       o_RX_Active,
   output logic       o_RX_Frame_Err
);
   localparam int CW = $clog2(CLKS_PER_BIT) + 1;
   localparam logic [CW-1:0] HALF = CW'((CLKS_PER_BIT - 1) / 2);
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
   typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;
   state_t        state_q;
   logic [1:0]    sync_q;
   logic [CW-1:0] cnt_q;
   logic [2:0]    idx_q;
   logic [7:0]    shift_q;
   logic          rx_s;
   assign rx_s = sync_q[1];
   always_ff @(posedge i_Clock or posedge i_Rst) begin
      if (i_Rst) begin
         state_q        <= IDLE;
         sync_q         <= 2'b11;
         cnt_q          <= '0;
         idx_q          <= '0;
         shift_q        <= '0;
         o_RX_DV        <= 1'b0;
         o_RX_Byte      <= '0;
         o_RX_Active    <= 1'b0;
         o_RX_Frame_Err <= 1'b0;
      end else begin
         sync_q         <= {sync_q[0], i_RX_Serial};
         o_RX_DV        <= 1'b0;
         o_RX_Frame_Err <= 1'b0;
         case (state_q)
            IDLE: begin
               cnt_q <= '0;
               idx_q <= '0;
               if (!rx_s) begin
                  state_q     <= START;
                  o_RX_Active <= 1'b1;
               end
            end
            START: begin
               if (cnt_q == HALF) begin
                  cnt_q <= '0;
                  if (!rx_s) state_q <= DATA;
                  else begin
                     state_q     <= IDLE;
                     o_RX_Active <= 1'b0;
                  end
               end else cnt_q <= cnt_q + CW'(1);
            end
            DATA: begin
               if (cnt_q == LAST) begin
                  cnt_q          <= '0;
                  shift_q[idx_q] <= rx_s;
                  idx_q          <= idx_q + 3'd1;
                  if (idx_q == 3'd7) state_q <= STOP;
               end else cnt_q <= cnt_q + CW'(1);
            end
            STOP: begin
               if (cnt_q == LAST) begin
                  cnt_q       <= '0;
                  o_RX_Active <= 1'b0;
                  if (rx_s) begin
                     o_RX_Byte <= shift_q;
                     o_RX_DV   <= 1'b1;
                     state_q   <= IDLE;
                  end else begin
                     o_RX_Frame_Err <= 1'b1;
                     state_q        <= WAIT_HIGH;
                  end
               end else cnt_q <= cnt_q + CW'(1);
            end
            // Hold off until the line recovers so a break cannot retrigger frames.
            WAIT_HIGH: if (rx_s) state_q <= IDLE;
            default: begin
               state_q     <= IDLE;
               o_RX_Active <= 1'b0;
            end
         endcase
      end
   end
endmodule
